// File: rtl/game_seq_pkg.sv
// game_seq_pkg: shared status encodings, default widths and helpers for the game sequencer
package game_seq_pkg;
   localparam int GAME_STATUS_BIT_LEN = 2;
   localparam int DEF_SCORE_W = 14;
   localparam int DEF_LIVES_W = 2;
   localparam int DEF_BOMB_W = 2;
   typedef enum logic [GAME_STATUS_BIT_LEN-1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DYING = 2'd2,
      ST_OVER  = 2'd3
   } game_status_e;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/game_seq_if.sv
// game_seq_if: collision/timing inputs and sprite/HUD outputs of the game sequencer
interface game_seq_if #(
   parameter int LIVES_W = game_seq_pkg::DEF_LIVES_W,
   parameter int BOMB_W  = game_seq_pkg::DEF_BOMB_W,
   parameter int SCORE_W = game_seq_pkg::DEF_SCORE_W
);
   logic v_sync_i;
   logic start_btn_i;
   logic bomb_btn_i;
   logic crash_me_enemy_i;
   logic crash_enemy_bullet_i;
   logic crash_me_bonus_i;
   logic [game_seq_pkg::GAME_STATUS_BIT_LEN-1:0] game_status_o;
   logic gamestart_o;
   logic bomb_o;
   logic [LIVES_W-1:0] lives_o;
   logic [SCORE_W-1:0] score_o;
   logic [BOMB_W-1:0] bombs_o;
   logic invuln_o;
   logic blink_o;
   modport master (
      output v_sync_i, start_btn_i, bomb_btn_i, crash_me_enemy_i, crash_enemy_bullet_i, crash_me_bonus_i,
      input  game_status_o, gamestart_o, bomb_o, lives_o, score_o, bombs_o, invuln_o, blink_o
   );
   modport slave (
      input  v_sync_i, start_btn_i, bomb_btn_i, crash_me_enemy_i, crash_enemy_bullet_i, crash_me_bonus_i,
      output game_status_o, gamestart_o, bomb_o, lives_o, score_o, bombs_o, invuln_o, blink_o
   );
endinterface

// File: rtl/game_seq_frame_flag.sv
// game_seq_frame_flag: folds a pixel-level strobe into one sticky event per frame
module game_seq_frame_flag (
   input  logic clk_vga,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic evt
);
   logic flag;
   always_ff @(posedge clk_vga or posedge rst)
      if (rst) flag <= 1'b0;
      else flag <= clr ? 1'b0 : (flag | set);
   assign evt = flag | set;
endmodule

// File: rtl/game_seq.sv
// game_seq: frame-level phase, lives, score, bomb and invulnerability sequencer for plane-war
module game_seq
   import game_seq_pkg::*;
#(
   parameter int LIVES_INIT    = 3,
   parameter int LIVES_W       = DEF_LIVES_W,
   parameter int BOMBS_INIT    = 1,
   parameter int MAX_BOMBS     = 3,
   parameter int BOMB_W        = DEF_BOMB_W,
   parameter int SCORE_W       = DEF_SCORE_W,
   parameter int SCORE_MAX     = 9999,
   parameter int DIE_FRAMES    = 60,
   parameter int INVULN_FRAMES = 120,
   parameter int OVER_FRAMES   = 90,
   parameter int BLINK_SHIFT   = 3
) (
   input logic clk_vga,
   input logic rst,
   game_seq_if.slave bus
);
   localparam int FC_MAX = max3(DIE_FRAMES, INVULN_FRAMES, OVER_FRAMES);
   localparam int FC_W = ($clog2(FC_MAX + 1) > BLINK_SHIFT) ? $clog2(FC_MAX + 1) : BLINK_SHIFT + 1;
   localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(LIVES_INIT);
   localparam logic [BOMB_W-1:0] B_INIT = BOMB_W'(BOMBS_INIT);
   localparam logic [BOMB_W-1:0] B_MAX = BOMB_W'(MAX_BOMBS);
   localparam logic [SCORE_W-1:0] S_MAX = SCORE_W'(SCORE_MAX);
   localparam logic [FC_W-1:0] FC_DIE = FC_W'(DIE_FRAMES);
   localparam logic [FC_W-1:0] FC_INV = FC_W'(INVULN_FRAMES);
   localparam logic [FC_W-1:0] FC_OVER = FC_W'(OVER_FRAMES);
   game_status_e state, state_n;
   logic [LIVES_W-1:0] lives, lives_n;
   logic [SCORE_W-1:0] score, score_n;
   logic [BOMB_W-1:0] bombs, bombs_n, bsum;
   logic [FC_W-1:0] fc, fc_n;
   logic inv, inv_n, arm, arm_n, bomb, bomb_n, gs, blink, blink_n;
   logic vs_q, st_q, bb_q, tick, start_p, bomb_p, load, use_b, hit, kill, bon;
   assign tick = vs_q & ~bus.v_sync_i;
   assign start_p = ~st_q & bus.start_btn_i;
   assign bomb_p = ~bb_q & bus.bomb_btn_i;
   assign load = start_p & (state == ST_IDLE | (state == ST_OVER & fc == '0));
   assign use_b = state == ST_PLAY & bomb_p & bombs != '0 & ~arm & ~bomb;
   game_seq_frame_flag u_hit (.clk_vga(clk_vga), .rst(rst), .set(bus.crash_me_enemy_i), .clr(tick | load), .evt(hit));
   game_seq_frame_flag u_kill (.clk_vga(clk_vga), .rst(rst), .set(bus.crash_enemy_bullet_i), .clr(tick | load), .evt(kill));
   game_seq_frame_flag u_bon (.clk_vga(clk_vga), .rst(rst), .set(bus.crash_me_bonus_i), .clr(tick | load), .evt(bon));
   always_comb begin
      state_n = state;
      lives_n = lives;
      score_n = score;
      bombs_n = bombs;
      bsum = bombs;
      fc_n = fc;
      inv_n = inv;
      arm_n = arm;
      bomb_n = bomb;
      if (load) begin
         state_n = ST_PLAY;
         lives_n = L_INIT;
         bombs_n = B_INIT;
         score_n = '0;
         fc_n = '0;
         inv_n = 1'b0;
         arm_n = 1'b0;
         bomb_n = 1'b0;
      end else if (state == ST_PLAY) begin
         bsum = (tick & bon & bombs < B_MAX) ? bombs + BOMB_W'(1) : bombs;
         bombs_n = use_b ? bsum - BOMB_W'(1) : bsum;
         arm_n = use_b | (arm & ~tick);
         bomb_n = tick ? arm : bomb;
         score_n = (tick & kill & score < S_MAX) ? score + SCORE_W'(1) : score;
         if (tick & hit & ~inv) begin
            state_n = ST_DYING;
            lives_n = lives - LIVES_W'(1);
            fc_n = FC_DIE;
            arm_n = 1'b0;
            bomb_n = 1'b0;
         end else if (tick & inv) begin
            fc_n = fc - FC_W'(1);
            inv_n = fc != FC_W'(1);
         end
      end else if (state == ST_DYING & tick) begin
         if (fc <= FC_W'(1)) begin
            state_n = (lives == '0) ? ST_OVER : ST_PLAY;
            inv_n = lives != '0;
            fc_n = (lives == '0) ? FC_OVER : FC_INV;
         end else fc_n = fc - FC_W'(1);
      end else if (state == ST_OVER & tick & fc != '0) fc_n = fc - FC_W'(1);
      blink_n = (state_n == ST_DYING) ? fc_n[BLINK_SHIFT-1] : (~inv_n | fc_n[BLINK_SHIFT]);
   end
   always_ff @(posedge clk_vga or posedge rst)
      if (rst) begin
         state <= ST_IDLE;
         lives <= '0;
         score <= '0;
         bombs <= '0;
         fc <= '0;
         inv <= 1'b0;
         arm <= 1'b0;
         bomb <= 1'b0;
         gs <= 1'b0;
         blink <= 1'b1;
         vs_q <= 1'b0;
         st_q <= 1'b0;
         bb_q <= 1'b0;
      end else begin
         state <= state_n;
         lives <= lives_n;
         score <= score_n;
         bombs <= bombs_n;
         fc <= fc_n;
         inv <= inv_n;
         arm <= arm_n;
         bomb <= bomb_n;
         gs <= load;
         blink <= blink_n;
         vs_q <= bus.v_sync_i;
         st_q <= bus.start_btn_i;
         bb_q <= bus.bomb_btn_i;
      end
   assign bus.game_status_o = state;
   assign bus.gamestart_o = gs;
   assign bus.bomb_o = bomb;
   assign bus.lives_o = lives;
   assign bus.score_o = score;
   assign bus.bombs_o = bombs;
   assign bus.invuln_o = inv;
   assign bus.blink_o = blink;
endmodule

// File: tb/tb_game_seq.sv
// tb_game_seq: directed and randomized frames checked every cycle against a behavioural game model
module tb_game_seq;
   localparam int LIVES_INIT = 3, BOMBS_INIT = 1, MAX_BOMBS = 3, SCORE_MAX = 9999;
   localparam int DIE_FRAMES = 60, INVULN_FRAMES = 120, OVER_FRAMES = 90, BLINK_SHIFT = 3;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   game_seq_if ifc ();
   game_seq dut (.clk_vga(clk), .rst(rst), .bus(ifc));
   int checks = 0, passes = 0, fails = 0;
   bit run = 1'b0;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
         if (fails >= 30) begin
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
         end
      end
   endtask
   // phase: 0 idle, 1 play, 2 dying, 3 over; left = frames remaining on the current timer
   int m_ph, m_lives, m_score, m_bombs, m_left;
   bit m_inv, m_arm, m_bomb, m_gs, pv, ps, pb, fk, fh, fb;
   bit t, sp, bp, ek, eh, eb, use_b, ng;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_lives = 0; m_score = 0; m_bombs = 0; m_left = 0;
         m_inv = 0; m_arm = 0; m_bomb = 0; m_gs = 0;
         pv = 0; ps = 0; pb = 0; fk = 0; fh = 0; fb = 0;
      end else begin
         t = pv && !ifc.v_sync_i;
         sp = !ps && ifc.start_btn_i;
         bp = !pb && ifc.bomb_btn_i;
         ek = fk || ifc.crash_enemy_bullet_i;
         eh = fh || ifc.crash_me_enemy_i;
         eb = fb || ifc.crash_me_bonus_i;
         ng = sp && (m_ph == 0 || (m_ph == 3 && m_left == 0));
         m_gs = ng;
         if (ng) begin
            m_ph = 1; m_lives = LIVES_INIT; m_bombs = BOMBS_INIT; m_score = 0;
            m_left = 0; m_inv = 0; m_arm = 0; m_bomb = 0;
         end else if (m_ph == 1) begin
            use_b = bp && m_bombs > 0 && !m_arm && !m_bomb;
            if (t) begin
               m_bomb = m_arm;
               m_arm = 0;
               if (ek && m_score < SCORE_MAX) m_score++;
               if (eb && m_bombs < MAX_BOMBS) m_bombs++;
            end
            if (use_b) begin
               m_arm = 1;
               m_bombs--;
            end
            if (t && eh && !m_inv) begin
               m_lives--; m_ph = 2; m_left = DIE_FRAMES; m_arm = 0; m_bomb = 0;
            end else if (t && m_inv) begin
               m_left--;
               if (m_left == 0) m_inv = 0;
            end
         end else if (m_ph == 2 && t) begin
            m_left--;
            if (m_left == 0) begin
               if (m_lives == 0) begin
                  m_ph = 3; m_left = OVER_FRAMES;
               end else begin
                  m_ph = 1; m_inv = 1; m_left = INVULN_FRAMES;
               end
            end
         end else if (m_ph == 3 && t && m_left > 0) m_left--;
         if (t || ng) begin
            fk = 0; fh = 0; fb = 0;
         end else begin
            fk = ek; fh = eh; fb = eb;
         end
         pv = ifc.v_sync_i; ps = ifc.start_btn_i; pb = ifc.bomb_btn_i;
      end
   end
   always @(negedge clk) if (run) begin
      chk("status", int'(ifc.game_status_o), m_ph);
      chk("gamestart", int'(ifc.gamestart_o), int'(m_gs));
      chk("bomb_o", int'(ifc.bomb_o), int'(m_bomb));
      chk("lives", int'(ifc.lives_o), m_lives);
      chk("score", int'(ifc.score_o), m_score);
      chk("bombs", int'(ifc.bombs_o), m_bombs);
      chk("invuln", int'(ifc.invuln_o), int'(m_inv));
      chk("blink", int'(ifc.blink_o), m_ph == 2 ? (m_left >> (BLINK_SHIFT - 1)) & 1 : int'(!m_inv || ((m_left >> BLINK_SHIFT) & 1) == 1));
   end
   task automatic tk();
      @(posedge clk);
      #2;
   endtask
   task automatic frame(input int len, input int pix, input bit k, input bit h, input bit b, input int st_at, input int bm_at);
      for (int i = 0; i < len; i++) begin
         ifc.v_sync_i = (i != len - 1);
         ifc.crash_enemy_bullet_i = k && i < pix;
         ifc.crash_me_enemy_i = h && i < pix;
         ifc.crash_me_bonus_i = b && i < pix;
         ifc.start_btn_i = (i == st_at);
         ifc.bomb_btn_i = (i == bm_at);
         tk();
      end
      ifc.crash_enemy_bullet_i = 0; ifc.crash_me_enemy_i = 0; ifc.crash_me_bonus_i = 0;
      ifc.start_btn_i = 0; ifc.bomb_btn_i = 0;
   endtask
   task automatic frames(input int n, input bit k = 0);
      for (int i = 0; i < n; i++) frame(3, 2, k, 0, 0, -1, -1);
   endtask
   task automatic start_game();
      ifc.start_btn_i = 1;
      tk();
      chk("start pulse", int'(ifc.gamestart_o), 1);
      chk("start status", int'(ifc.game_status_o), 1);
      ifc.start_btn_i = 0;
      tk();
      chk("start pulse end", int'(ifc.gamestart_o), 0);
   endtask
   task automatic chk_reset();
      chk("rst status", int'(ifc.game_status_o), 0);
      chk("rst lives", int'(ifc.lives_o), 0);
      chk("rst score", int'(ifc.score_o), 0);
      chk("rst bombs", int'(ifc.bombs_o), 0);
      chk("rst bomb_o", int'(ifc.bomb_o), 0);
      chk("rst gamestart", int'(ifc.gamestart_o), 0);
      chk("rst invuln", int'(ifc.invuln_o), 0);
      chk("rst blink", int'(ifc.blink_o), 1);
   endtask
   initial begin
      int len;
      rst = 1;
      ifc.v_sync_i = 1; ifc.start_btn_i = 0; ifc.bomb_btn_i = 0;
      ifc.crash_me_enemy_i = 0; ifc.crash_enemy_bullet_i = 0; ifc.crash_me_bonus_i = 0;
      tk(); tk(); tk();
      chk_reset();
      run = 1;
      rst = 0;
      tk();
      start_game();
      chk("new lives", int'(ifc.lives_o), 3);
      chk("new bombs", int'(ifc.bombs_o), 1);
      chk("new score", int'(ifc.score_o), 0);
      for (int i = 0; i < 5; i++) frame(210, 200, 1, 0, 0, -1, -1);
      chk("score 5", int'(ifc.score_o), 5);
      frame(4, 2, 0, 1, 0, -1, -1);
      chk("hit status", int'(ifc.game_status_o), 2);
      chk("hit lives", int'(ifc.lives_o), 2);
      frames(DIE_FRAMES - 1);
      chk("dying held", int'(ifc.game_status_o), 2);
      frames(1);
      chk("respawn status", int'(ifc.game_status_o), 1);
      chk("respawn invuln", int'(ifc.invuln_o), 1);
      frames(1);
      chk("blink low", int'(ifc.blink_o), 0);
      frames(8);
      chk("blink high", int'(ifc.blink_o), 1);
      frame(4, 2, 0, 1, 0, -1, -1);
      chk("immune lives", int'(ifc.lives_o), 2);
      chk("immune status", int'(ifc.game_status_o), 1);
      frames(INVULN_FRAMES - 11);
      chk("invuln last", int'(ifc.invuln_o), 1);
      frames(1);
      chk("invuln cleared", int'(ifc.invuln_o), 0);
      frame(4, 0, 0, 0, 0, -1, 0);
      chk("bomb used", int'(ifc.bombs_o), 0);
      chk("bomb fired", int'(ifc.bomb_o), 1);
      frames(1);
      chk("bomb ended", int'(ifc.bomb_o), 0);
      frame(4, 0, 0, 0, 0, -1, 0);
      frames(1);
      chk("empty bomb", int'(ifc.bomb_o), 0);
      frame(4, 2, 0, 1, 0, -1, -1);
      frames(DIE_FRAMES + INVULN_FRAMES);
      frame(4, 2, 0, 1, 0, -1, -1);
      chk("last life", int'(ifc.lives_o), 0);
      frames(DIE_FRAMES);
      chk("over", int'(ifc.game_status_o), 3);
      frames(49);
      frame(3, 0, 0, 0, 0, 0, -1);
      chk("early start", int'(ifc.game_status_o), 3);
      frames(OVER_FRAMES - 50);
      frame(3, 0, 0, 0, 0, 0, -1);
      chk("restart status", int'(ifc.game_status_o), 1);
      chk("restart lives", int'(ifc.lives_o), 3);
      frame(3, 2, 0, 0, 1, -1, -1);
      frame(3, 2, 0, 0, 1, -1, -1);
      chk("bombs full", int'(ifc.bombs_o), 3);
      frame(3, 2, 1, 1, 1, -1, -1);
      chk("combo score", int'(ifc.score_o), 1);
      chk("combo bombs", int'(ifc.bombs_o), 3);
      chk("combo lives", int'(ifc.lives_o), 2);
      chk("combo status", int'(ifc.game_status_o), 2);
      frames(5);
      rst = 1;
      tk();
      chk_reset();
      tk();
      rst = 0;
      tk();
      start_game();
      frames(SCORE_MAX - 1, 1);
      chk("score near max", int'(ifc.score_o), SCORE_MAX - 1);
      frames(1, 1);
      chk("score max", int'(ifc.score_o), SCORE_MAX);
      frames(1, 1);
      chk("score saturated", int'(ifc.score_o), SCORE_MAX);
      for (int f = 0; f < 2500; f++) begin
         len = int'($urandom_range(2, 10));
         frame(len, int'($urandom_range(0, len)), $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
               $urandom_range(0, 4) == 0,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1);
      end
      tk();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
